// File: rtl/intr_arbiter.sv
// ----------------------------------------------------------------------------
// intr_arbiter
//   Shares the MCU's single interrupt input among up to N_SRC sources.
//   Rising edges on src_irq are latched into PEND, qualified by MASK, and the
//   lowest-index qualified source wins. intr is held until software writes
//   the winner's id to ACK. A one-cycle GAP then guarantees a visible low
//   between back-to-back interrupts.
//
//   Register block (exact address match only):
//     BASE+0  MASK  RW   bits [N_SRC-1:0], 1 = enabled
//     BASE+4  PEND  R/W1C
//     BASE+8  ACK   WO   data[2:0] = id being acknowledged, reads 0
//
// Ports:
//   clk         system clock
//   RST         asynchronous active-high reset
//   src_irq     source interrupt lines (synchronous to clk)
//   iobus_addr  IOBUS address
//   iobus_out   IOBUS write data
//   iobus_wr    IOBUS write strobe
//   rd_data     read data for the wrapper's input mux (0 when no hit)
//   intr        interrupt request to the MCU
//   active_id   id of the current winner, valid while intr = 1
// ----------------------------------------------------------------------------
module intr_arbiter #(
  parameter int          N_SRC     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h1100E000
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [N_SRC-1:0] src_irq,
  input  logic [31:0]      iobus_addr,
  input  logic [31:0]      iobus_out,
  input  logic             iobus_wr,
  output logic [31:0]      rd_data,
  output logic             intr,
  output logic [2:0]       active_id
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t           state;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] prev;

  logic             hit_mask, hit_pend, hit_ack;
  logic             ack_hit;
  logic [N_SRC-1:0] rise, w1c, ack_clr, pend_nxt, mask_nxt, req;
  logic [7:0]       mask8, pend8;
  logic             active_keep;
  logic [2:0]       win;

  // Only low write-data bits are meaningful; the rest are ignored by design.
  logic unused_wdata;
  assign unused_wdata = ^iobus_out;

  // Fixed priority: lowest index among the requesting bits.
  function automatic logic [2:0] prio_win(input logic [N_SRC-1:0] r);
    logic [2:0] w;
    w = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (r[i]) w = 3'(i);
    return w;
  endfunction

  assign hit_mask = (iobus_addr == BASE_ADDR);
  assign hit_pend = (iobus_addr == BASE_ADDR + 32'd4);
  assign hit_ack  = (iobus_addr == BASE_ADDR + 32'd8);

  assign rise     = src_irq & ~prev;
  assign w1c      = (iobus_wr && hit_pend) ? iobus_out[N_SRC-1:0] : '0;
  assign mask_nxt = (iobus_wr && hit_mask) ? iobus_out[N_SRC-1:0] : mask;
  assign ack_hit  = iobus_wr && hit_ack && (state == REQ) &&
                    (iobus_out[2:0] == active_id);

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < N_SRC; i++)
      ack_clr[i] = ack_hit && (active_id == 3'(i));
  end

  // A new rise beats a same-cycle clear so no event is ever lost.
  assign pend_nxt = (pend & ~w1c & ~ack_clr) | rise;

  // Widen to 8 bits so a 3-bit id can index without range issues.
  assign mask8       = 8'(mask_nxt);
  assign pend8       = 8'(pend_nxt);
  assign active_keep = mask8[active_id] & pend8[active_id];

  assign req = pend & mask;
  assign win = prio_win(req);

  always_comb begin
    rd_data = '0;
    if (hit_mask)      rd_data = 32'(mask);
    else if (hit_pend) rd_data = 32'(pend);
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      intr      <= 1'b0;
      active_id <= '0;
      mask      <= '0;
      pend      <= '0;
      prev      <= '0;
    end else begin
      prev <= src_irq;
      mask <= mask_nxt;
      pend <= pend_nxt;
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= REQ;
            intr      <= 1'b1;
            active_id <= win;
          end
        end
        REQ: begin
          // Software withdrawing the winner (mask or W1C) cancels the request.
          if (ack_hit) begin
            state <= GAP;
            intr  <= 1'b0;
          end else if (!active_keep) begin
            state <= IDLE;
            intr  <= 1'b0;
          end
        end
        GAP: begin
          state <= IDLE;
          intr  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          intr  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intr_arbiter.sv
module tb_intr_arbiter;

  localparam logic [31:0] BASE   = 32'h1100E000;
  localparam logic [31:0] A_MASK = BASE;
  localparam logic [31:0] A_PEND = BASE + 32'd4;
  localparam logic [31:0] A_ACK  = BASE + 32'd8;

  logic        clk;
  logic        RST;
  logic [3:0]  src_irq;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] rd_data;
  logic        intr;
  logic [2:0]  active_id;

  int n_assert = 0;
  int n_fail   = 0;

  intr_arbiter #(.N_SRC(4), .BASE_ADDR(BASE)) dut (
    .clk(clk), .RST(RST), .src_irq(src_irq),
    .iobus_addr(iobus_addr), .iobus_out(iobus_out), .iobus_wr(iobus_wr),
    .rd_data(rd_data), .intr(intr), .active_id(active_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    iobus_addr = a;
    iobus_out  = d;
    iobus_wr   = 1'b1;
    tick();
    iobus_wr   = 1'b0;
    iobus_out  = '0;
    iobus_addr = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    iobus_addr = a;
    #1;
    d = rd_data;
    iobus_addr = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    RST = 1'b1;
    tick();
    tick();
    n_assert++; if (intr !== 1'b0) begin n_fail++; $display("FAIL reset_intr: got %b want 0", intr); end
    n_assert++; if (active_id !== 3'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", active_id); end
    bus_read(A_MASK, d);
    n_assert++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mask: got %h want 0", d); end
    bus_read(A_PEND, d);
    n_assert++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_pend: got %h want 0", d); end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [31:0] d;
    bus_write(A_MASK, 32'hF);
    src_irq = 4'b0100;
    tick();
    src_irq = 4'b0000;
    bus_read(A_PEND, d);
    n_assert++; if (d !== 32'h4) begin n_fail++; $display("FAIL single_pend: got %h want 4", d); end
    n_assert++; if (intr !== 1'b0) begin n_fail++; $display("FAIL single_intr_early: got %b want 0", intr); end
    tick();
    n_assert++; if (intr !== 1'b1) begin n_fail++; $display("FAIL single_intr: got %b want 1", intr); end
    n_assert++; if (active_id !== 3'd2) begin n_fail++; $display("FAIL single_id: got %0d want 2", active_id); end
    bus_write(A_ACK, 32'h2);
    n_assert++; if (intr !== 1'b0) begin n_fail++; $display("FAIL single_ack_intr: got %b want 0", intr); end
    bus_read(A_PEND, d);
    n_assert++; if (d !== 32'h0) begin n_fail++; $display("FAIL single_ack_pend: got %h want 0", d); end
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    src_irq = 4'b1010;
    tick();
    src_irq = 4'b0000;
    bus_read(A_PEND, d);
    n_assert++; if (d !== 32'hA) begin n_fail++; $display("FAIL b2b_pend: got %h want a", d); end
    tick();
    n_assert++; if (intr !== 1'b1) begin n_fail++; $display("FAIL b2b_intr1: got %b want 1", intr); end
    n_assert++; if (active_id !== 3'd1) begin n_fail++; $display("FAIL b2b_id1: got %0d want 1", active_id); end
    bus_write(A_ACK, 32'h1);
    n_assert++; if (intr !== 1'b0) begin n_fail++; $display("FAIL b2b_gap1: got %b want 0", intr); end
    bus_read(A_PEND, d);
    n_assert++; if (d !== 32'h8) begin n_fail++; $display("FAIL b2b_pend_after: got %h want 8", d); end
    tick();
    n_assert++; if (intr !== 1'b0) begin n_fail++; $display("FAIL b2b_gap2: got %b want 0", intr); end
    tick();
    n_assert++; if (intr !== 1'b1) begin n_fail++; $display("FAIL b2b_intr3: got %b want 1", intr); end
    n_assert++; if (active_id !== 3'd3) begin n_fail++; $display("FAIL b2b_id3: got %0d want 3", active_id); end
    bus_write(A_ACK, 32'h3);
    n_assert++; if (intr !== 1'b0) begin n_fail++; $display("FAIL b2b_ack3: got %b want 0", intr); end
    tick();
    tick();
  endtask

  task automatic test_wrong_ack_mask();
    logic [31:0] d;
    src_irq = 4'b0010;
    tick();
    src_irq = 4'b0000;
    tick();
    n_assert++; if (intr !== 1'b1 || active_id !== 3'd1) begin n_fail++; $display("FAIL wack_setup: got intr=%b id=%0d want intr=1 id=1", intr, active_id); end
    bus_write(A_ACK, 32'h0);
    n_assert++; if (intr !== 1'b1) begin n_fail++; $display("FAIL wack_intr: got %b want 1", intr); end
    n_assert++; if (active_id !== 3'd1) begin n_fail++; $display("FAIL wack_id: got %0d want 1", active_id); end
    bus_read(A_PEND, d);
    n_assert++; if (d !== 32'h2) begin n_fail++; $display("FAIL wack_pend: got %h want 2", d); end
    bus_write(A_MASK, 32'hD);
    n_assert++; if (intr !== 1'b0) begin n_fail++; $display("FAIL mask_drop_intr: got %b want 0", intr); end
    bus_read(A_PEND, d);
    n_assert++; if (d !== 32'h2) begin n_fail++; $display("FAIL mask_drop_pend: got %h want 2", d); end
    bus_write(A_MASK, 32'hF);
    tick();
    n_assert++; if (intr !== 1'b1 || active_id !== 3'd1) begin n_fail++; $display("FAIL mask_restore: got intr=%b id=%0d want intr=1 id=1", intr, active_id); end
    bus_write(A_ACK, 32'h1);
    tick();
    tick();
  endtask

  task automatic test_level_hold();
    logic [31:0] d;
    bus_write(A_MASK, 32'h0);
    src_irq = 4'b0001;
    repeat (20) tick();
    bus_read(A_PEND, d);
    n_assert++; if (d !== 32'h1) begin n_fail++; $display("FAIL hold_pend: got %h want 1", d); end
    n_assert++; if (intr !== 1'b0) begin n_fail++; $display("FAIL hold_masked_intr: got %b want 0", intr); end
    bus_write(A_PEND, 32'h1);
    bus_read(A_PEND, d);
    n_assert++; if (d !== 32'h0) begin n_fail++; $display("FAIL hold_single_event: got %h want 0", d); end
    src_irq = 4'b0000;
    tick();
    src_irq = 4'b0100;
    bus_write(A_PEND, 32'h4);
    bus_read(A_PEND, d);
    n_assert++; if (d !== 32'h4) begin n_fail++; $display("FAIL set_beats_clear: got %h want 4", d); end
    src_irq = 4'b0000;
    bus_write(A_PEND, 32'h4);
    bus_read(A_PEND, d);
    n_assert++; if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_clear: got %h want 0", d); end
  endtask

  task automatic test_bus_decode();
    logic [31:0] d;
    bus_write(A_MASK, 32'hA);
    bus_read(A_MASK, d);
    n_assert++; if (d !== 32'h0000000A) begin n_fail++; $display("FAIL rd_mask: got %h want 0000000a", d); end
    bus_read(A_ACK, d);
    n_assert++; if (d !== 32'h0) begin n_fail++; $display("FAIL rd_ack: got %h want 0", d); end
    bus_read(32'h11008000, d);
    n_assert++; if (d !== 32'h0) begin n_fail++; $display("FAIL rd_miss: got %h want 0", d); end
    bus_write(BASE + 32'd12, 32'hFFFFFFFF);
    bus_read(A_MASK, d);
    n_assert++; if (d !== 32'hA) begin n_fail++; $display("FAIL wr_miss_mask: got %h want a", d); end
    bus_read(A_PEND, d);
    n_assert++; if (d !== 32'h0) begin n_fail++; $display("FAIL wr_miss_pend: got %h want 0", d); end
    iobus_addr = A_MASK;
    iobus_out  = 32'h5;
    iobus_wr   = 1'b0;
    tick();
    iobus_addr = '0;
    iobus_out  = '0;
    bus_read(A_MASK, d);
    n_assert++; if (d !== 32'hA) begin n_fail++; $display("FAIL no_strobe: got %h want a", d); end
    bus_write(A_MASK, 32'hFFFFFFF5);
    bus_read(A_MASK, d);
    n_assert++; if (d !== 32'h5) begin n_fail++; $display("FAIL upper_bits: got %h want 5", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus_write(A_MASK, 32'hF);
    src_irq = 4'b0101;
    tick();
    src_irq = 4'b0000;
    tick();
    n_assert++; if (intr !== 1'b1 || active_id !== 3'd0) begin n_fail++; $display("FAIL rmid_setup: got intr=%b id=%0d want intr=1 id=0", intr, active_id); end
    bus_read(A_PEND, d);
    n_assert++; if (d !== 32'h5) begin n_fail++; $display("FAIL rmid_pend_setup: got %h want 5", d); end
    #1;
    RST = 1'b1;
    #1;
    n_assert++; if (intr !== 1'b0) begin n_fail++; $display("FAIL rmid_intr: got %b want 0", intr); end
    n_assert++; if (active_id !== 3'd0) begin n_fail++; $display("FAIL rmid_id: got %0d want 0", active_id); end
    bus_read(A_MASK, d);
    n_assert++; if (d !== 32'h0) begin n_fail++; $display("FAIL rmid_mask: got %h want 0", d); end
    bus_read(A_PEND, d);
    n_assert++; if (d !== 32'h0) begin n_fail++; $display("FAIL rmid_pend: got %h want 0", d); end
    tick();
    RST = 1'b0;
    tick();
    tick();
    n_assert++; if (intr !== 1'b0) begin n_fail++; $display("FAIL rmid_after: got %b want 0", intr); end
  endtask

  initial begin
    RST        = 1'b1;
    src_irq    = '0;
    iobus_addr = '0;
    iobus_out  = '0;
    iobus_wr   = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_wrong_ack_mask();
    test_level_hold();
    test_bus_decode();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/intr_arbiter.md
Name: intr_arbiter

Overview:
- Priority interrupt arbiter: shares the MCU's single `intr` input among up to `N_SRC` interrupt sources (timer-counter `tc_intr`, buttons, future peripherals).
- Latches source edges into pending bits, masks them, selects one winner and holds `intr` until software acknowledges the winner over the IOBUS.
- Sits in the wrapper between the peripherals and the MCU `intr` pin. Decodes its own IOBUS registers and returns read data for the wrapper's input mux.

Parameters:
- N_SRC, 4, number of interrupt sources (1..8); index 0 is highest priority.
- BASE_ADDR, 32'h1100E000, base of the 3-word register block.

Ports:
- clk  input  1  system clock (MCU clock domain)
- RST  input  1  reset, asynchronous, active-high
- src_irq  input  N_SRC  source interrupt lines, synchronous to clk; a rising edge requests service
- iobus_addr  input  32  MCU IOBUS address
- iobus_out  input  32  MCU IOBUS write data
- iobus_wr  input  1  MCU IOBUS write strobe
- rd_data  output  32  register read data; 0 when the address does not hit the block
- intr  output  1  interrupt request to the MCU
- active_id  output  3  id of the current winner; valid while intr=1

Behaviour:
- Register map:
  - BASE+0 MASK: RW; bits [N_SRC-1:0]; 1 = enabled.
  - BASE+4 PEND: read returns pending bits; writing 1 to a bit clears it (W1C).
  - BASE+8 ACK: write-only, reads 0; write data [2:0] = id being acknowledged.
- Reset (async, immediate): MASK=0, PEND=0, edge-history register=0, state=IDLE, intr=0, active_id=0, rd_data follows the cleared registers.
- Edge detect: per bit, `rise = src_irq & ~prev`. `prev` registers `src_irq` every clk. A rise sets the PEND bit on the next edge.
  - A source held high produces exactly one pending event.
  - Pulses of one cycle are caught.
- Simultaneous set and W1C clear on the same bit in the same cycle: set wins, bit stays 1.
- Masked sources still set PEND; they are only excluded from arbitration.
- Arbitration is fixed priority. Winner = lowest index i with PEND[i] & MASK[i].
- FSM, all registered:
  - IDLE: intr=0. If any `PEND & MASK` is set, latch the winner into active_id and go to REQ.
  - REQ: intr=1, active_id frozen.
    - A write to ACK with data[2:0]==active_id clears PEND[active_id] and moves to GAP.
    - An ACK with a mismatched id is ignored; stay in REQ.
    - If MASK[active_id] or PEND[active_id] goes to 0 (software write), go to IDLE with intr=0 next cycle. No other PEND bit changes.
  - GAP: intr=0 for exactly one cycle, then IDLE. Guarantees a visible low between back-to-back interrupts.
- Latency:
  - Source rise at edge k → PEND set at k+1 → REQ / intr=1 at k+2.
  - ACK write at edge a → intr=0 at a+1.
  - Next pending winner drives intr=1 at a+3 (GAP at a+1, IDLE at a+2).
- Preemption: a higher-priority source arriving during REQ does not replace active_id. It wins at the next IDLE.
- rd_data is combinational from iobus_addr:
  - MASK → zero-extended MASK.
  - PEND → zero-extended PEND.
  - Any other address, including ACK → 0.
- Writes take effect only when iobus_wr=1 and the address matches exactly. Unused upper write bits are ignored.
- Reset asserted mid-REQ drops intr and clears all state immediately (asynchronous).

Test Plan:
- Reset: assert RST mid-sim with PEND=4'b0101 and state REQ → intr=0, PEND=0, MASK=0 with no clk edge required.
- Single source: MASK=4'hF; pulse src_irq[2] for 1 cycle at edge k → PEND=4'b0100 at k+1, intr=1 and active_id=2 at k+2. Write ACK=2 → intr=0 next cycle, PEND=0.
- Priority/back-to-back: raise src_irq[3] and src_irq[1] together, MASK=4'hF → active_id=1 first. After ACK=1: intr low for exactly 2 cycles, then active_id=3.
- Wrong ACK / masking:
  - In REQ with active_id=1, write ACK=0 → intr stays 1, PEND unchanged.
  - Write MASK=4'b1101 → intr=0 next cycle; PEND[1] still 1.
  - Restore MASK=4'hF → intr=1 again with active_id=1.
- Level hold and set-vs-clear: hold src_irq[0] high for 20 cycles → only one pending event. In the cycle a new rise on bit 2 arrives, W1C-write PEND=4'b0100 → PEND[2] remains 1.
- Bus decode: read BASE+0 with MASK=4'hA → rd_data=32'h0000000A. Read BASE+8 → 0. Read 32'h11008000 → 0. Write to BASE+12 → no register change.
